bsg_credit_arb_rr: RTL and testbench

BSG_CREDIT_ARB_RR -- requirements
Module: bsg_credit_arb_rr

---
 rtl/bsg_credit_arb_pkg.sv | 9 +
 rtl/bsg_credit_arb_rr_sel.sv | 31 +++
 rtl/bsg_credit_arb_rr.sv | 117 +++++++++++
 tb/tb_bsg_credit_arb_rr.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/bsg_credit_arb_pkg.sv
// Shared types for the credit-flow-controlled round-robin arbiter.
package bsg_credit_arb_pkg;

  typedef enum logic [0:0] {
    StArb,
    StLock
  } arb_state_e;

endpackage

// File: rtl/bsg_credit_arb_rr_sel.sv
// Round-robin first-request finder: search starts at i_ptr and wraps modulo num_req_p.
module bsg_credit_arb_rr_sel #(
  parameter int unsigned num_req_p = 4,
  localparam int unsigned lg_req_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
  input  logic [num_req_p-1:0] i_req,
  input  logic [lg_req_lp-1:0] i_ptr,
  output logic [num_req_p-1:0] o_grant,
  output logic [lg_req_lp-1:0] o_idx
);

  logic        w_found;
  int unsigned w_j;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_j     = 0;
    for (int unsigned k = 0; k < num_req_p; k++) begin
      w_j = 32'(i_ptr) + k;
      if (w_j >= num_req_p) w_j = w_j - num_req_p;
      if (!w_found && i_req[w_j[lg_req_lp-1:0]]) begin
        w_found                        = 1'b1;
        o_grant[w_j[lg_req_lp-1:0]]    = 1'b1;
        o_idx                          = w_j[lg_req_lp-1:0];
      end
    end
  end

endmodule

// File: rtl/bsg_credit_arb_rr.sv
// Packet-atomic round-robin arbiter feeding one credit-flow-controlled output channel.
module bsg_credit_arb_rr
  import bsg_credit_arb_pkg::*;
#(
  parameter int unsigned num_req_p                       = 4,
  parameter int unsigned max_credits_p                   = 16,
  parameter int unsigned lg_credit_to_token_decimation_p = 0,
  localparam int unsigned credit_w_lp = $clog2(max_credits_p + 1),
  localparam int unsigned lg_req_lp   = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [num_req_p-1:0]   v_i,
  input  logic [num_req_p-1:0]   last_i,
  output logic [num_req_p-1:0]   yumi_o,
  output logic                   v_o,
  output logic [num_req_p-1:0]   grant_o,
  input  logic                   token_i,
  input  logic                   infinite_credits_i,
  output logic [credit_w_lp-1:0] credits_o,
  output logic                   error_o
);

  // Wide enough to hold credits + one token without wrapping before the clamp.
  localparam int unsigned sum_w_lp = credit_w_lp + lg_credit_to_token_decimation_p + 1;
  localparam logic [sum_w_lp-1:0] token_val_lp =
    sum_w_lp'(1) << lg_credit_to_token_decimation_p;
  localparam logic [sum_w_lp-1:0] max_lp = sum_w_lp'(max_credits_p);

  arb_state_e             r_state, w_state_d;
  logic [lg_req_lp-1:0]   r_lock_idx, w_lock_idx_d;
  logic [lg_req_lp-1:0]   r_ptr, w_ptr_d;
  logic [credit_w_lp-1:0] r_credits, w_credits_d;
  logic                   r_error, w_error_d;

  logic [num_req_p-1:0] w_sel_grant, w_grant;
  logic [lg_req_lp-1:0] w_sel_idx, w_winner;
  logic                 w_avail, w_send, w_last;
  logic [sum_w_lp-1:0]  w_sum;

  bsg_credit_arb_rr_sel #(
    .num_req_p(num_req_p)
  ) u_sel (
    .i_req  (v_i),
    .i_ptr  (r_ptr),
    .o_grant(w_sel_grant),
    .o_idx  (w_sel_idx)
  );

  assign w_avail = (r_credits != '0) | infinite_credits_i;

  // Grant depends only on v_i and state; credits gate yumi, never grant.
  always_comb begin
    w_grant  = '0;
    w_winner = w_sel_idx;
    if (!reset_i) begin
      if (r_state == StArb) begin
        w_grant = w_sel_grant;
      end else begin
        w_winner             = r_lock_idx;
        w_grant[r_lock_idx]  = v_i[r_lock_idx];
      end
    end
  end

  assign grant_o = w_grant;
  assign yumi_o  = w_grant & {num_req_p{w_avail}};
  assign w_send  = |yumi_o;
  assign v_o     = w_send;
  assign w_last  = |(yumi_o & last_i);

  always_comb begin
    w_state_d    = r_state;
    w_lock_idx_d = r_lock_idx;
    w_ptr_d      = r_ptr;
    if (w_send) begin
      if (w_last) begin
        w_state_d = StArb;
        w_ptr_d   = (w_winner == lg_req_lp'(num_req_p - 1)) ? '0 : w_winner + 1'b1;
      end else if (r_state == StArb) begin
        w_state_d    = StLock;
        w_lock_idx_d = w_winner;
      end
    end
  end

  always_comb begin
    w_error_d = r_error;
    w_sum     = sum_w_lp'(r_credits) + (token_i ? token_val_lp : '0);
    if (w_send && (w_sum != '0)) w_sum = w_sum - 1'b1;
    if (w_sum > max_lp) begin
      w_sum     = max_lp;
      w_error_d = 1'b1;
    end
    w_credits_d = w_sum[credit_w_lp-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state    <= StArb;
      r_lock_idx <= '0;
      r_ptr      <= '0;
      r_credits  <= credit_w_lp'(max_credits_p);
      r_error    <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_lock_idx <= w_lock_idx_d;
      r_ptr      <= w_ptr_d;
      r_credits  <= w_credits_d;
      r_error    <= w_error_d;
    end
  end

  assign credits_o = r_credits;
  assign error_o   = r_error;

endmodule

// File: tb/tb_bsg_credit_arb_rr.sv
// Directed and randomized checks of bsg_credit_arb_rr against a packet-level reference model.
module tb_bsg_credit_arb_rr;

  localparam int N   = 4;
  localparam int MAX = 16;
  localparam int LG  = 2;
  localparam int TOK = 1 << LG;

  logic       clk = 1'b0;
  logic       reset_i = 1'b1;
  logic [3:0] v_i = '0, last_i = '0, yumi_o, grant_o;
  logic       v_o, token_i = 1'b0, infinite_credits_i = 1'b0, error_o;
  logic [4:0] credits_o;

  bsg_credit_arb_rr #(
    .num_req_p                      (N),
    .max_credits_p                  (MAX),
    .lg_credit_to_token_decimation_p(LG)
  ) dut (
    .clk_i             (clk),
    .reset_i           (reset_i),
    .v_i               (v_i),
    .last_i            (last_i),
    .yumi_o            (yumi_o),
    .v_o               (v_o),
    .grant_o           (grant_o),
    .token_i           (token_i),
    .infinite_credits_i(infinite_credits_i),
    .credits_o         (credits_o),
    .error_o           (error_o)
  );

  always #5 clk = ~clk;

  // Reference model: packet owner (-1 when free), next-priority requester, credit pool.
  int m_owner, m_ptr, m_cred;
  logic m_err;
  int n_cmp = 0, n_err = 0;
  logic [3:0] obs_yumi;
  int acc, order [5];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input logic [3:0] oh);
    for (int i = 0; i < N; i++) if (oh[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_cred = MAX; m_err = 1'b0;
  endtask

  task automatic step(input logic [3:0] v, input logic [3:0] last, input logic tok,
                      input logic inf, input logic rst);
    logic [3:0] exp_y;
    int w;
    v_i = v; last_i = last; token_i = tok; infinite_credits_i = inf; reset_i = rst;
    #2;
    exp_y = '0;
    w = -1;
    if (!rst) begin
      if (m_owner >= 0) begin
        if (v[m_owner]) w = m_owner;
      end else begin
        for (int k = N - 1; k >= 0; k--) if (v[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      end
      if (w >= 0 && (m_cred > 0 || inf)) exp_y[w] = 1'b1;
    end
    check("yumi", 32'(yumi_o), 32'(exp_y));
    check("v_o", 32'(v_o), 32'(|exp_y));
    if (|exp_y) check("grant", 32'(grant_o), 32'(exp_y));
    check("credits", 32'(credits_o), 32'(m_cred));
    check("error", 32'(error_o), 32'(m_err));
    obs_yumi = yumi_o;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (|exp_y) begin
        if (last[w]) begin
          m_owner = -1;
          m_ptr   = (w + 1) % N;
        end else begin
          m_owner = w;
        end
      end
      m_cred = m_cred - ((|exp_y) ? 1 : 0) + (tok ? TOK : 0);
      if (m_cred < 0) m_cred = 0;
      if (m_cred > MAX) begin
        m_cred = MAX;
        m_err  = 1'b1;
      end
    end
    #1;
  endtask

  initial begin
    reset_i = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    model_reset();
    step(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1);

    // Drain all credits with single-flit packets from requester 0.
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      step(4'b0001, 4'b0001, 1'b0, 1'b0, 1'b0);
      if (obs_yumi != 0) acc++;
    end
    check("drain_count", 32'(acc), 32'd16);
    check("drain_credits", 32'(credits_o), 32'd0);

    // Infinite credits at zero: flit goes, counter stays at zero.
    step(4'b0001, 4'b0001, 1'b0, 1'b1, 1'b0);
    check("inf_send", 32'(obs_yumi), 32'b0001);
    check("inf_zero", 32'(credits_o), 32'd0);

    // One token worth four credits.
    step(4'b0001, 4'b0001, 1'b1, 1'b0, 1'b0);
    check("tok_no_send", 32'(obs_yumi), 32'd0);
    check("tok_credits", 32'(credits_o), 32'd4);
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      step(4'b0001, 4'b0001, 1'b0, 1'b0, 1'b0);
      if (obs_yumi != 0) acc++;
    end
    check("tok_count", 32'(acc), 32'd4);

    // Round-robin order with all requesting single flits.
    step(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, 4'b1111, 1'b0, 1'b0, 1'b0);
      order[i] = idx_of(obs_yumi);
    end
    check("rr0", 32'(order[0]), 32'd0);
    check("rr1", 32'(order[1]), 32'd1);
    check("rr2", 32'(order[2]), 32'd2);
    check("rr3", 32'(order[3]), 32'd3);
    check("rr4", 32'(order[4]), 32'd0);

    // Requester 1 owns a 3-flit packet with a 2-cycle bubble.
    step(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1);
    step(4'b0001, 4'b0001, 1'b0, 1'b0, 1'b0);
    step(4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0);
    check("lock_f1", 32'(obs_yumi), 32'b0010);
    step(4'b1101, 4'b1101, 1'b0, 1'b0, 1'b0);
    check("lock_gap1", 32'(obs_yumi), 32'd0);
    step(4'b1101, 4'b1101, 1'b0, 1'b0, 1'b0);
    check("lock_gap2", 32'(obs_yumi), 32'd0);
    step(4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0);
    check("lock_f2", 32'(obs_yumi), 32'b0010);
    step(4'b1111, 4'b1111, 1'b0, 1'b0, 1'b0);
    check("lock_f3", 32'(obs_yumi), 32'b0010);
    step(4'b1111, 4'b1111, 1'b0, 1'b0, 1'b0);
    check("lock_next", 32'(obs_yumi), 32'b0100);

    // Token at full credit saturates and sets a sticky error.
    step(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1);
    step(4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
    check("sat_credits", 32'(credits_o), 32'd16);
    check("sat_err", 32'(error_o), 32'd1);
    for (int i = 0; i < 3; i++) step(4'b0001, 4'b0001, 1'b0, 1'b0, 1'b0);
    check("sat_sticky", 32'(error_o), 32'd1);

    // Reset while requester 3 holds a lock.
    step(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1);
    step(4'b1000, 4'b0000, 1'b0, 1'b0, 1'b0);
    check("rst_lock", 32'(obs_yumi), 32'b1000);
    step(4'b1000, 4'b0000, 1'b0, 1'b0, 1'b1);
    check("rst_quiet", 32'(obs_yumi), 32'd0);
    step(4'b1001, 4'b1001, 1'b0, 1'b0, 1'b0);
    check("rst_grant0", 32'(obs_yumi), 32'b0001);
    check("rst_err", 32'(error_o), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(4'($urandom), 4'($urandom), $urandom_range(0, 3) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 99) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
